// File: rtl/dff9.sv
// dff9: D flip-flop with complementary outputs and optional pipeline depth.
//
// Leaf storage primitive for a registered value and its inverse. DEPTH stages
// are chained from d to q; every stage loads RESET_VAL asynchronously while
// reset is low. Legal DEPTH range is 1..8.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous reset, active low (0 = asserted)
//   d      in   WIDTH  data input, sampled on rising clk
//   q      out  WIDTH  last pipeline stage
//   qb     out  WIDTH  bitwise complement of the last pipeline stage
module dff9 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      DEPTH     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = d;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  // Both outputs come from the same stage so qb always tracks ~q.
  assign q  = stage_q[DEPTH-1];
  assign qb = ~stage_q[DEPTH-1];

endmodule

// File: tb/tb_dff9.sv
// Self-checking bench for dff9: a default 1-bit/1-stage instance and a
// WIDTH=4, RESET_VAL=4'hA, DEPTH=3 instance, both driven with random data.
module tb_dff9;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_a;
  logic [3:0] d_b;
  logic       q_a, qb_a;
  logic [3:0] q_b, qb_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dff9 #(.WIDTH(1), .RESET_VAL(1'b0), .DEPTH(1)) u_a (
    .clk(clk), .reset(reset), .d(d_a), .q(q_a), .qb(qb_a)
  );

  dff9 #(.WIDTH(4), .RESET_VAL(4'hA), .DEPTH(3)) u_b (
    .clk(clk), .reset(reset), .d(d_b), .q(q_b), .qb(qb_b)
  );

  // Reference: instance A shows the last sampled d; instance B keeps a
  // history of the last three samples and shows the oldest one.
  logic       exp_a;
  logic [3:0] hist_b[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_a  = 1'b0;
      hist_b = '{4'hA, 4'hA, 4'hA};
    end else begin
      exp_a = d_a;
      hist_b.push_front(d_b);
      void'(hist_b.pop_back());
    end
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic       ea, eab;
    logic [3:0] eb, ebb;
    ea  = exp_a;
    eab = ~exp_a;
    eb  = hist_b[2];
    ebb = ~eb;
    check({tag, "_qa"},  q_a,  ea);
    check({tag, "_qba"}, qb_a, eab);
    check({tag, "_qb"},  q_b,  eb);
    check({tag, "_qbb"}, qb_b, ebb);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic pat [5];
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with unknown data.
    reset = 1'b1;
    d_a   = 1'bx;
    d_b   = 4'bxxxx;
    #1 reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #2;
      check_all("rst_x");
      check("rst_qa_const", q_a, 4'h0);
      check("rst_qba_const", qb_a, 4'h1);
      check("rst_qb_const", q_b, 4'hA);
      check("rst_qbb_const", qb_b, 4'h5);
    end

    // Release between edges; capture on the next rising edge.
    @(negedge clk);
    d_a = 1'b1;
    d_b = 4'h3;
    #1 reset = 1'b1;
    #1 check("rel_hold_qa", q_a, 4'h0);
    check("rel_hold_qb", q_b, 4'hA);
    @(posedge clk); #2;
    check_all("rel1");
    check("rel1_qa_const", q_a, 4'h1);
    @(posedge clk); #2;
    check_all("rel2");
    check("rel2_qb_const", q_b, 4'hA);
    @(posedge clk); #2;
    check_all("rel3");
    check("rel3_qb_const", q_b, 4'h3);
    check("rel3_qbb_const", qb_b, 4'hC);

    // Asynchronous reset during the clock-low phase.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_all("arst");
    check("arst_qa_const", q_a, 4'h0);
    check("arst_qb_const", q_b, 4'hA);
    #1 reset = 1'b1;
    @(posedge clk); #2;
    check_all("arst_rel");
    check("arst_rel_qa_const", q_a, 4'h1);

    // Fixed 0,1,0,1,0 pattern then random data, changed at random mid-cycle times.
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 check_all("edge");
      #($urandom_range(1, 5));
      if (i < 5) d_a = pat[i];
      else       d_a = 1'($urandom());
      d_b = 4'($urandom());
      #1 check_all("mid");
      if (i >= 5 && $urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        #1 check_all("mid_rst");
        reset = 1'b1;
      end
    end

    // Release coincident with a rising edge: that edge stays in reset.
    @(negedge clk);
    reset = 1'b0;
    d_a   = 1'b1;
    d_b   = 4'h3;
    // Nonblocking so the release lands just after the flops evaluate this edge.
    @(posedge clk) reset <= 1'b1;
    #2;
    check_all("coin0");
    check("coin0_qa_const", q_a, 4'h0);
    @(posedge clk); #2;
    check_all("coin1");
    check("coin1_qa_const", q_a, 4'h1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check_all("coin3");
    check("coin3_qb_const", q_b, 4'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff9.md
Name: dff9

Overview:
- D flip-flop with complementary outputs `q` and `qb`, one clock domain, asynchronous active-low reset.
- Leaf storage primitive used wherever a registered bit and its inverse are needed.
- Parameterised for width, reset value and pipeline depth. The default instance is a single 1-bit flop.

Parameters:
- WIDTH, 1, bit width of `d`, `q` and `qb`.
- RESET_VAL, 0 (WIDTH bits), value loaded into every stage on reset.
- DEPTH, 1, number of register stages from `d` to `q`; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. 0 = asserted, 1 = released.
- d  input  WIDTH  data input, sampled on the rising edge of `clk`.
- q  output  WIDTH  registered data, taken from the last stage.
- qb  output  WIDTH  bitwise complement of `q`.

Behaviour:
- Storage: DEPTH registers s[0]..s[DEPTH-1], chained s[0] <- d and s[k] <- s[k-1].
- Outputs:
  - q = s[DEPTH-1].
  - qb = ~s[DEPTH-1], driven from the same stage so that qb == ~q at all times outside reset-release.
  - No combinational path from `d` to `q` or `qb`.
- Reset assertion (falling edge of `reset`, or `reset` low at any time):
  - All stages load RESET_VAL immediately, with no dependence on `clk`.
  - Result: q = RESET_VAL, qb = ~RESET_VAL.
- While `reset` = 0:
  - Outputs hold their reset values regardless of `clk` edges.
  - `d` is ignored; `d` = X must not propagate to `q` or `qb`.
- Reset release:
  - Synchronous-style behaviour after release: the first rising `clk` edge with `reset` = 1 captures `d` into s[0].
  - Release coincident with a rising `clk` edge: the flop stays in reset for that edge and captures on the next edge.
- Latency: `d` sampled at edge N appears on `q` after edge N+DEPTH-1 (DEPTH = 1: visible immediately after the capturing edge).
- Between rising edges, a change on `d` has no effect on `q` or `qb`.
- Reset mid-operation: contents are discarded immediately. After release, the pipeline refills from `d`, with reset values flushing out over DEPTH edges.
- Initial state before the first reset is undefined. A bench must apply reset before checking.
- X on `d` while out of reset is captured and propagated as X; no X-masking.
- Falling edges of `clk` have no effect.

Test Plan:
- Reset with `d` = X: drive `reset` = 0 and `d` = 1'bx for several clocks -> q = 0, qb = 1 throughout, no X on either output.
- Release and capture: `d` = 1, `reset` 0->1 between edges -> q/qb remain 0/1 until the next rising `clk`, then q = 1, qb = 0.
- Asynchronous reset while q = 1: drop `reset` to 0 mid clock-low phase -> q = 0, qb = 1 immediately, without waiting for a clock edge. Release -> the next edge recaptures `d` = 1.
- Data sequence: drive d = 0,1,0,1,0 at random non-edge-aligned times -> after each rising edge, q equals the value of `d` just before that edge and qb = ~q. No output change between edges.
- Reset/clock coincidence: release `reset` exactly at a rising edge with `d` = 1 -> q stays 0 for that edge and becomes 1 on the following edge.
- Parameter sweep with WIDTH = 4, RESET_VAL = 4'hA, DEPTH = 3: reset -> q = 4'hA, qb = 4'h5. After release, drive d = 4'h3 -> q = 4'h3 after the third rising edge, with qb == ~q at every check.
